// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// Latency: none; this is wiring only.
// Backpressure: valid/ready on both the request side and the response side.
interface alu_arbiter_if;
  typedef logic [31:0] word_t;

  logic  req0_valid;
  logic  req0_ready;
  word_t req0_a;
  word_t req0_b;
  word_t req0_ctrl;
  logic  req1_valid;
  logic  req1_ready;
  word_t req1_a;
  word_t req1_b;
  word_t req1_ctrl;

  logic  rsp0_valid;
  logic  rsp0_ready;
  word_t rsp0_data;
  logic  rsp1_valid;
  logic  rsp1_ready;
  word_t rsp1_data;

  word_t alu_a;
  word_t alu_b;
  word_t alu_ctrl;
  word_t alu_result;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result
  );

  // Requester / ALU side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU; one op in flight at a time.
// Latency: accept at T, ALU driven T+1, response valid from T+2 (3 cycles minimum per op).
// Backpressure: response held until owner's rsp ready; no request accepted meanwhile.
// Optional macro ALU_ARBITER_RR_EN: round-robin on contention (default: port 0 wins).
module alu_arbiter (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_q, state_d;
  word_t  a_q, b_q, ctrl_q, result_q;
  logic   owner_q;
  logic   grant_sel;
  logic   accept;
  logic   rsp_fire;

`ifdef ALU_ARBITER_RR_EN
  logic   last_grant_q;

  // Round-robin pick: on contention, favour the port that was not granted last.
  always_comb begin
    grant_sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = bus.req1_valid;
    end
  end
`else
  // Fixed priority pick: port 1 only when port 0 is not requesting.
  always_comb begin
    grant_sel = 1'b0;
    grant_sel = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // Next state and request-side handshake; readies are held low during reset.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    rsp_fire       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          bus.req0_ready = bus.req0_valid & ~grant_sel;
          bus.req1_ready = bus.req1_valid &  grant_sel;
        end
        accept = bus.req0_ready | bus.req1_ready;
        if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_fire = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive the shared ALU only during ISSUE so it sees a no-op otherwise.
  always_comb begin
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = '0;
    if (state_q == ISSUE) begin
      bus.alu_a    = a_q;
      bus.alu_b    = b_q;
      bus.alu_ctrl = ctrl_q;
    end
  end

  // Route the held result to the owning port only; the other port reads zero.
  always_comb begin
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_data  = '0;
    bus.rsp1_data  = '0;
    if (state_q == RESP) begin
      if (owner_q) begin
        bus.rsp1_valid = 1'b1;
        bus.rsp1_data  = result_q;
      end else begin
        bus.rsp0_valid = 1'b1;
        bus.rsp0_data  = result_q;
      end
    end
  end

  // State register; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept, result capture at the end of ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      owner_q      <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      if (accept) begin
        a_q          <= grant_sel ? bus.req1_a    : bus.req0_a;
        b_q          <= grant_sel ? bus.req1_b    : bus.req0_b;
        ctrl_q       <= grant_sel ? bus.req1_ctrl : bus.req0_ctrl;
        owner_q      <= grant_sel;
`ifdef ALU_ARBITER_RR_EN
        last_grant_q <= grant_sel;
`endif
      end
      if (state_q == ISSUE) begin
        result_q <= bus.alu_result;
      end
    end
  end

endmodule
